// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - field-level instruction encoder with buffered IMEM loader
//
// Packs opcode/register/immediate requests into 16-bit words, drops opcodes the
// decoder treats as unused, and streams accepted words into IMEM at sequential
// addresses through a small FIFO.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, finish               session begin (address 0) / no more requests
//   in_valid, in_ready          request handshake
//   in_op, in_rs, in_rt, in_rd  opcode and register fields
//   in_imm                      immediate [4:0] or jump target [10:0]
//   imem_we, imem_gnt           IMEM write request / grant
//   imem_addr, imem_data        IMEM write address and encoded word
//   busy, done                  session active / session complete
//   err_illegal, illegal_cnt    sticky reject flag and saturating reject count
//
// Optional feature macro: NOP_PAD_EN (pad the rest of IMEM with 16'h0000 after draining).

module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [10:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [7:0]        illegal_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
`ifdef NOP_PAD_EN
    localparam logic [2:0] S_PAD   = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic logic [15:0] encode(input logic [4:0] op, input logic [2:0] rs,
                                           input logic [2:0] rt, input logic [2:0] rd,
                                           input logic [10:0] imm);
        if (op[4:3] == 2'b00)
            encode = {op, rs, rt, rd, 2'b00};
        else if (op == 5'b11001)
            encode = {op, imm};
        else
            encode = {op, rs, rt, imm[4:0]};
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        is_legal = op inside {[5'd0:5'd6], 5'd8, [5'd10:5'd14], [5'd16:5'd19],
                              5'd25, 5'd26, 5'd28};
    endfunction

    logic [2:0]        state;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W:0]    count;
    logic              head_fresh;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_we;
    logic              pad_we;
    logic              advance;

    assign in_ready = (state == S_LOAD) && (count != FIFO_FULL_CNT) && !finish;
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_legal(in_op);

    // A word pushed straight into the head slot is held back one extra cycle so
    // the write request never appears earlier than two cycles after acceptance.
    assign fifo_we  = (count != '0) && !head_fresh;
`ifdef NOP_PAD_EN
    assign pad_we   = (state == S_PAD);
`else
    assign pad_we   = 1'b0;
`endif
    assign imem_we   = fifo_we || pad_we;
    assign pop       = fifo_we && imem_gnt;
    assign advance   = imem_we && imem_gnt;
    assign imem_addr = addr;
    assign imem_data = fifo_we ? mem[rd_idx] : 16'h0000;
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= encode(in_op, in_rs, in_rt, in_rd, in_imm);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_idx      <= '0;
            wr_idx      <= '0;
            count       <= '0;
            head_fresh  <= 1'b0;
            addr        <= '0;
            err_illegal <= 1'b0;
            illegal_cnt <= 8'd0;
        end else begin
            if (push)
                wr_idx <= wr_idx + 1'b1;
            if (pop)
                rd_idx <= rd_idx + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            head_fresh <= push && ((count == '0) || ((count == 1) && pop));

            if (advance)
                addr <= addr + 1'b1;

            if (accept && !is_legal(in_op)) begin
                err_illegal <= 1'b1;
                if (illegal_cnt != 8'hFF)
                    illegal_cnt <= illegal_cnt + 8'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        addr        <= '0;
                        err_illegal <= 1'b0;
                        illegal_cnt <= 8'd0;
                    end
                end
                S_LOAD: begin
                    if (finish)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (count == '0) begin
`ifdef NOP_PAD_EN
                        state <= (addr == '0) ? S_DONE : S_PAD;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef NOP_PAD_EN
                S_PAD: begin
                    if (advance && (&addr))
                        state <= S_DONE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
